// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage around a combinational ALU: one operation in flight, registered
// operands toward the ALU, registered result and zero flag toward the consumer.
//
// state | meaning
// IDLE  | empty, ready to accept an operation
// EXEC  | operands registered, ALU settling; result captured at end of cycle
// DONE  | result presented; may accept the next operation when the result is taken
module alu_issue_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_sel,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [1:0]         r_alu_sel;
    logic [WIDTH-1:0]   r_out_result;
    logic [1:0]         r_out_sel;
    logic               r_out_zero;
    logic [CNT_W-1:0]   r_op_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = in_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // in_ready in DONE follows out_ready so a new op can enter as the result leaves
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = out_ready;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = w_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
        end else if (w_in_fire) begin
            r_alu_a   <= in_a;
            r_alu_b   <= in_b;
            r_alu_sel <= in_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_result <= '0;
            r_out_sel    <= '0;
            r_out_zero   <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_out_result <= alu_out;
            r_out_sel    <= r_alu_sel;
            r_out_zero   <= (alu_out == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_out_fire) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign out_result = r_out_result;
    assign out_sel    = r_out_sel;
    assign out_zero   = r_out_zero;
    assign op_count   = r_op_count;

endmodule
